dial_digit_sequencer: RTL and testbench

Buffers up to DEPTH telephone digits written by the OTTER over the memory-mapped IOBUS. On command, it plays them out one at a time to the Arduino dialer as a 4-bit digit plus an enable strobe, with fixed hold and gap times. It sits between the wrapper's IOBUS write decode (ARDUINO_NUMBER_AD) and the ARDUINO_NUM/ARDUINO_EN pins. It replaces ad-hoc per-slot registers, the digit mux and the external delay logic with a single sequenced controller.

---
 rtl/dial_pkg.sv | 19 +
 rtl/dial_timer.sv | 27 ++
 rtl/dial_digit_sequencer.sv | 166 ++++++++++++++++
 tb/tb_dial_digit_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dial_pkg.sv
// Shared command codes, FSM state type and helpers for the dial digit sequencer.
// The optional abort command is enabled by defining DIAL_ABORT_EN.
package dial_pkg;

  localparam logic [7:0] CMD_COMMIT = 8'hFF;
  localparam logic [7:0] CMD_ABORT  = 8'hFE;
  localparam logic [7:0] DIGIT_MAX  = 8'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } dial_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dial_timer.sv
// Loadable down-counter with a zero flag; shared by the HOLD and GAP phases.
module dial_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dial_digit_sequencer.sv
// Buffers digits written over the IOBUS and plays them out to the Arduino
// dialer with fixed hold/gap timing. Define DIAL_ABORT_EN to accept the
// abort command (0xFE) in any state.
module dial_digit_sequencer
  import dial_pkg::*;
#(
  parameter int unsigned DEPTH       = 10,
  parameter int unsigned HOLD_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR,
  input  logic [7:0] WR_DATA,
  output logic [3:0] NUM_OUT,
  output logic       EN_OUT,
  output logic       BUSY,
  output logic [3:0] COUNT,
  output logic       DROPPED,
  output logic       DONE
);

  localparam int unsigned MAXC    = max_u(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned TW      = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_SLOT = 4'(DEPTH - 1);

  dial_state_t state_q;
  logic [3:0]  rd_idx_q;
  logic [3:0]  count_q;
  logic [3:0]  num_q;
  logic        en_q;
  logic        busy_q;
  logic        dropped_q;
  logic        done_q;
  logic [3:0]  digits_q [DEPTH];

  logic          is_digit_c, is_commit_c, abort_c;
  logic          push_c, start_c, reject_c, last_c;
  logic [3:0]    first_digit_c;
  logic          tmr_load_c, tmr_zero_c;
  logic [TW-1:0] tmr_val_c;

  // Write decode, accept/reject decisions and timer load control.
  always_comb begin
    is_digit_c  = WR && (WR_DATA <= DIGIT_MAX);
    is_commit_c = WR && (WR_DATA == CMD_COMMIT);
`ifdef DIAL_ABORT_EN
    abort_c     = WR && (WR_DATA == CMD_ABORT);
`else
    abort_c     = 1'b0;
`endif
    push_c   = (state_q == IDLE) && is_digit_c;
    start_c  = (state_q == IDLE) &&
               ((is_digit_c && (count_q == LAST_SLOT)) ||
                (is_commit_c && (count_q != 4'd0)));
    reject_c = WR && !abort_c &&
               ((state_q != IDLE) || !(is_digit_c || is_commit_c));
    last_c   = (rd_idx_q == (count_q - 4'd1));
    // An auto-dial from an empty buffer plays the digit being written now.
    first_digit_c = (count_q == 4'd0) ? WR_DATA[3:0] : digits_q[0];

    tmr_load_c = 1'b0;
    tmr_val_c  = HOLD_LD;
    if (start_c) begin
      tmr_load_c = 1'b1;
    end else if ((state_q == HOLD) && tmr_zero_c) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = GAP_LD;
    end else if ((state_q == GAP) && tmr_zero_c && !last_c) begin
      tmr_load_c = 1'b1;
    end
  end

  dial_timer #(.W(TW)) u_timer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .zero_o     (tmr_zero_c)
  );

  // Digit storage; contents are only meaningful below count_q.
  always_ff @(posedge CLK) begin
    if (push_c) begin
      digits_q[count_q] <= WR_DATA[3:0];
    end
  end

  // Dial sequencing FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      rd_idx_q  <= 4'd0;
      count_q   <= 4'd0;
      num_q     <= 4'd0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_c) begin
        state_q   <= IDLE;
        rd_idx_q  <= 4'd0;
        count_q   <= 4'd0;
        num_q     <= 4'd0;
        en_q      <= 1'b0;
        busy_q    <= 1'b0;
        dropped_q <= 1'b0;
      end else begin
        if (reject_c) begin
          dropped_q <= 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (push_c) begin
              count_q <= count_q + 4'd1;
            end
            if (start_c) begin
              state_q   <= HOLD;
              rd_idx_q  <= 4'd0;
              num_q     <= first_digit_c;
              en_q      <= 1'b1;
              busy_q    <= 1'b1;
              dropped_q <= 1'b0;
            end
          end
          HOLD: begin
            if (tmr_zero_c) begin
              state_q <= GAP;
              num_q   <= 4'd0;
              en_q    <= 1'b0;
            end
          end
          GAP: begin
            if (tmr_zero_c) begin
              if (last_c) begin
                state_q  <= IDLE;
                rd_idx_q <= 4'd0;
                count_q  <= 4'd0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                state_q  <= HOLD;
                rd_idx_q <= rd_idx_q + 4'd1;
                num_q    <= digits_q[rd_idx_q + 4'd1];
                en_q     <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign NUM_OUT = num_q;
  assign EN_OUT  = en_q;
  assign BUSY    = busy_q;
  assign COUNT   = count_q;
  assign DROPPED = dropped_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_dial_digit_sequencer.sv
// Self-checking bench for dial_digit_sequencer (DEPTH=10, HOLD=3, GAP=2).
// Honors DIAL_ABORT_EN when the design is built with it.
module tb_dial_digit_sequencer;

  logic       clk, rst_n, wr;
  logic [7:0] wr_data;
  logic [3:0] num_out, count;
  logic       en_out, busy, dropped, done;

  dial_digit_sequencer #(.DEPTH(10), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .WR(wr), .WR_DATA(wr_data),
    .NUM_OUT(num_out), .EN_OUT(en_out), .BUSY(busy),
    .COUNT(count), .DROPPED(dropped), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         drop;
    int         bsy;
  } vec_t;

  vec_t       tbl [6];
  logic [3:0] exp_q [$];
  int total = 0, bad = 0;
  int cyc = 0;
  logic en_prev = 1'b0;
  int hi_len = 0, lo_len = 0, rises = 0;
  logic fell = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock, then observe outputs and score the EN_OUT/NUM_OUT stream.
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    cyc++;
    fell = 1'b0;
    if (en_out && !en_prev) begin
      rises++;
      if (lo_len != 0) chk("gap_len", lo_len, 2);
      lo_len = 0;
      hi_len = 1;
      if (exp_q.size() == 0) begin
        chk("digit_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("digit_value", num_out, e);
      end
    end else if (en_out) begin
      hi_len++;
    end else if (en_prev) begin
      chk("hold_len", hi_len, 3);
      chk("gap_num_zero", num_out, 0);
      lo_len = 1;
      fell = 1'b1;
    end else if (lo_len != 0) begin
      lo_len++;
    end
    if (done) begin
      chk("done_gap_len", lo_len, 3);
      chk("done_queue_empty", exp_q.size(), 0);
      chk("done_count", count, 0);
      chk("done_busy", busy, 0);
      lo_len = 0;
    end
    en_prev = en_out;
  endtask

  task automatic wr1(input logic [7:0] d);
    wr = 1'b1;
    wr_data = d;
    tick();
    wr = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", int'(at >= 0), 1);
  endtask

  task automatic wait_fall(input int budget);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (fell) begin
        ok = 1;
        break;
      end
    end
    chk("en_fall_seen", ok, 1);
  endtask

  initial begin
    int c0, dc, seen_en, seen_done, ok;

    tbl[0] = '{8'h05, 1, 0, 0};
    tbl[1] = '{8'h05, 2, 0, 0};
    tbl[2] = '{8'h0A, 2, 1, 0};
    tbl[3] = '{8'h01, 3, 1, 0};
    tbl[4] = '{8'h80, 3, 1, 0};
    tbl[5] = '{8'hFF, 3, 0, 1};

    rst_n = 1'b0; wr = 1'b0; wr_data = 8'h00;
    #3;
    chk("rst_num", num_out, 0);
    chk("rst_en", en_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_done", done, 0);
    #9 rst_n = 1'b1;
    tick();

    // Commit with an empty buffer is ignored and not flagged.
    wr1(8'hFF);
    seen_en = 0;
    for (int k = 0; k < 4; k++) begin
      seen_en |= int'(en_out | busy | dropped);
      if (k < 3) tick();
    end
    chk("empty_commit_quiet", seen_en, 0);

    // Pushes, invalid codes and commit from a table.
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].data <= 8'h09) exp_q.push_back(tbl[i].data[3:0]);
      wr1(tbl[i].data);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_dropped", i), dropped, tbl[i].drop);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      c0 = cyc;
    end
    chk("commit_en", en_out, 1);
    tick(); tick();
    wr1(8'h03);
    chk("busy_push_dropped", dropped, 1);
    chk("busy_push_count", count, 3);
    wait_done(100, dc);
    chk("dial3_len", dc - c0, 15);
    chk("dropped_sticky", dropped, 1);
    // A write in the DONE cycle is an idle write.
    exp_q.push_back(4'd9);
    wr1(8'h09);
    chk("done_pulse_one", done, 0);
    chk("done_cycle_push", count, 1);

    // Second dial with 0xFE issued during the gap.
    exp_q.push_back(4'd4);
    wr1(8'h04);
    chk("push2_count", count, 2);
    wr1(8'hFF);
    c0 = cyc;
    chk("commit_clears_dropped", dropped, 0);
    chk("commit2_busy", busy, 1);
    wait_fall(20);
    wr1(8'hFE);
`ifdef DIAL_ABORT_EN
    chk("abort_busy", busy, 0);
    chk("abort_en", en_out, 0);
    chk("abort_num", num_out, 0);
    chk("abort_count", count, 0);
    chk("abort_dropped", dropped, 0);
    exp_q.delete();
    lo_len = 0;
    seen_en = 0; seen_done = 0;
    for (int k = 0; k < 15; k++) begin
      seen_en |= int'(en_out);
      seen_done |= int'(done);
      tick();
    end
    chk("abort_no_en", seen_en, 0);
    chk("abort_no_done", seen_done, 0);
`else
    chk("fe_dropped", dropped, 1);
    chk("fe_busy", busy, 1);
    wait_done(100, dc);
    chk("dial2_len", dc - c0, 10);
`endif

    // Auto-dial on the tenth push.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(4'(i));
      wr1(8'(i));
      if (i < 9) begin
        chk($sformatf("auto_count%0d", i), count, i + 1);
        chk($sformatf("auto_idle%0d", i), busy, 0);
      end else begin
        chk("auto_count_full", count, 10);
        chk("auto_busy", busy, 1);
        chk("auto_en", en_out, 1);
        c0 = cyc;
      end
    end
    wait_done(200, dc);
    chk("dial10_len", dc - c0, 50);

    // Asynchronous reset during the second digit's hold.
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd8);
    wr1(8'h07);
    wr1(8'h08);
    rises = 0;
    wr1(8'hFF);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (rises == 2) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("second_digit_seen", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", en_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    exp_q.delete();
    en_prev = 1'b0; lo_len = 0; hi_len = 0;
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_busy", busy, 0);
    exp_q.push_back(4'd3);
    wr1(8'h03);
    chk("post_rst_push", count, 1);
    wr1(8'hFF);
    c0 = cyc;
    wait_done(50, dc);
    chk("dial1_len", dc - c0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
